// File: rtl/fmap_seq.sv
// Feature-map buffer sequencer: raster fill of a 16-bank buffer, then same-padded 3x3 tap replay.
// Latency: writes land on the accept edge; rd_addr 1 cycle and tap flags 2 cycles after tap issue.
// Backpressure: in_ready drops once the map is full; the scan itself never stalls.
module fmap_seq #(
  parameter int ADDR_WIDTH = 8,
  parameter int ROWS       = 14,
  parameter int COLS       = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  fmap_full,
  input  logic                  rd_start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data_valid,
  output logic                  rd_pad,
  output logic                  rd_tap_last,
  output logic                  rd_win_last,
  output logic                  done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(ROWS * COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] COLS_A   = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] NEG_COLS = ADDR_WIDTH'(-COLS);
  localparam logic [RW-1:0]         ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0]         COL_LAST = CW'(COLS - 1);

  typedef enum logic [2:0] {IDLE, FILL, FULL, SCAN, FLUSH} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_cnt;
  logic [ADDR_WIDTH-1:0]   row_base;   // row * COLS, kept incrementally
  logic [RW-1:0]           row;
  logic [CW-1:0]           col;
  logic [1:0]              kr;         // tap row index, dr = kr - 1
  logic [1:0]              kc;         // tap column index, dc = kc - 1

  logic                    tap_pad;
  logic                    tap_last;
  logic                    scan_last;
  logic [ADDR_WIDTH-1:0]   tap_addr;
  logic [ADDR_WIDTH-1:0]   row_off;

  logic                    v1;
  logic                    pad1;
  logic                    tl1;
  logic                    wl1;

  // Write side and status levels are pure state decodes.
  assign in_ready  = (state == IDLE) || (state == FILL);
  assign wr_en     = in_valid & in_ready;
  assign wr_addr   = wr_cnt;
  assign fmap_full = (state == FULL);
  assign done      = (state == FLUSH);

  // Tap address and pad decode. Modular AW-bit arithmetic is exact for in-range taps;
  // out-of-range taps produce garbage here but are replaced by 0 in the pipeline.
  always_comb begin
    tap_pad   = 1'b0;
    tap_last  = 1'b0;
    scan_last = 1'b0;
    row_off   = '0;
    tap_addr  = '0;
    if ((kr == 2'd0 && row == '0) || (kr == 2'd2 && row == ROW_LAST) ||
        (kc == 2'd0 && col == '0) || (kc == 2'd2 && col == COL_LAST))
      tap_pad = 1'b1;
    if (kr == 2'd0)
      row_off = NEG_COLS;
    else if (kr == 2'd2)
      row_off = COLS_A;
    tap_addr  = row_base + ADDR_WIDTH'(col) + row_off + ADDR_WIDTH'(kc) - ADDR_WIDTH'(1);
    tap_last  = (kr == 2'd2) && (kc == 2'd2);
    scan_last = tap_last && (col == COL_LAST) && (row == ROW_LAST);
  end

  // Main FSM: fill counter, scan counters (tap inner, column, row outer).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      row_base <= '0;
      row      <= '0;
      col      <= '0;
      kr       <= '0;
      kc       <= '0;
    end else begin
      case (state)
        IDLE, FILL: begin
          if (wr_en) begin
            wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
            state  <= (wr_cnt == LAST_PIX) ? FULL : FILL;
          end
        end
        FULL: begin
          if (rd_start)
            state <= SCAN;
        end
        SCAN: begin
          if (kc == 2'd2) begin
            kc <= 2'd0;
            if (kr == 2'd2) begin
              kr <= 2'd0;
              if (col == COL_LAST) begin
                col      <= '0;
                row_base <= row_base + COLS_A;
                row      <= (row == ROW_LAST) ? '0 : row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end else begin
              kr <= kr + 2'd1;
            end
          end else begin
            kc <= kc + 2'd1;
          end
          if (scan_last)
            state <= FLUSH;
        end
        FLUSH: begin
          wr_cnt   <= '0;
          row_base <= '0;
          row      <= '0;
          col      <= '0;
          kr       <= '0;
          kc       <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read pipeline: stage 1 registers the address, stage 2 aligns flags with bank rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr       <= '0;
      v1            <= 1'b0;
      pad1          <= 1'b0;
      tl1           <= 1'b0;
      wl1           <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_pad        <= 1'b0;
      rd_tap_last   <= 1'b0;
      rd_win_last   <= 1'b0;
    end else begin
      v1            <= (state == SCAN);
      pad1          <= (state == SCAN) && tap_pad;
      tl1           <= (state == SCAN) && tap_last;
      wl1           <= (state == SCAN) && scan_last;
      rd_addr       <= ((state == SCAN) && !tap_pad) ? tap_addr : '0;
      rd_data_valid <= v1;
      rd_pad        <= pad1;
      rd_tap_last   <= tl1;
      rd_win_last   <= wl1;
    end
  end

endmodule

// File: tb/tb_fmap_seq.sv
// Directed bench for fmap_seq: fill, throttled fill, full window scan, async reset mid-scan.
// Tap stream is recorded per cycle and compared against an arithmetic reference.
// Producer throttling is random on/off of in_valid.
module tb_fmap_seq;

  localparam int AW    = 8;
  localparam int ROWS  = 14;
  localparam int COLS  = 14;
  localparam int NPIX  = ROWS * COLS;
  localparam int NTAP  = NPIX * 9;
  localparam int NREC  = NTAP + 6;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          fmap_full;
  logic          rd_start;
  logic [AW-1:0] rd_addr;
  logic          rd_data_valid;
  logic          rd_pad;
  logic          rd_tap_last;
  logic          rd_win_last;
  logic          done;

  int total = 0;
  int bad   = 0;

  int rec_addr [NREC];
  int rec_val  [NREC];
  int rec_pad  [NREC];
  int rec_tl   [NREC];
  int rec_wl   [NREC];
  int rec_done [NREC];
  int rec_rdy  [NREC];

  fmap_seq #(.ADDR_WIDTH(AW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .fmap_full     (fmap_full),
    .rd_start      (rd_start),
    .rd_addr       (rd_addr),
    .rd_data_valid (rd_data_valid),
    .rd_pad        (rd_pad),
    .rd_tap_last   (rd_tap_last),
    .rd_win_last   (rd_win_last),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference tap: window w = n/9 in raster order, tap k = n%9, dr outer, dc inner.
  function automatic int ref_pad(input int n);
    int w, k, rr, cc;
    w  = n / 9;
    k  = n % 9;
    rr = w / COLS + k / 3 - 1;
    cc = w % COLS + k % 3 - 1;
    return (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ? 1 : 0;
  endfunction

  function automatic int ref_addr(input int n);
    int w, k, rr, cc;
    w  = n / 9;
    k  = n % 9;
    rr = w / COLS + k / 3 - 1;
    cc = w % COLS + k % 3 - 1;
    return (ref_pad(n) != 0) ? 0 : rr * COLS + cc;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_fmap_full"}, int'(fmap_full), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_rd_valid"}, int'(rd_data_valid), 0);
    chk({tag, "_rd_pad"}, int'(rd_pad), 0);
    chk({tag, "_tap_last"}, int'(rd_tap_last), 0);
    chk({tag, "_win_last"}, int'(rd_win_last), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // Randomly throttled fill; every write must carry the next sequential address.
  task automatic fill_rand(input string tag);
    int n   = 0;
    int cyc = 0;
    while (!fmap_full && cyc < 3000) begin
      in_valid = 1'($urandom_range(0, 1));
      #1;
      if (wr_en) begin
        chk({tag, "_seq"}, int'(wr_addr), n);
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_count"}, n, NPIX);
    chk({tag, "_full"}, int'(fmap_full), 1);
  endtask

  // Pulse rd_start so it is sampled at exactly one edge while in FULL.
  task automatic start_scan();
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  initial begin
    int addr_tab [9];
    int pad_tab  [9];
    int tl_cnt, wl_cnt, dn_cnt, v_cnt;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    rd_start = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous fill: one write per cycle, addresses 0..NPIX-1.
    chk("fill_rdy0", int'(in_ready), 1);
    for (int i = 0; i < NPIX; i++) begin
      in_valid = 1'b1;
      #1;
      chk("fill_wr_en", int'(wr_en), 1);
      chk("fill_addr", int'(wr_addr), i);
      @(posedge clk); #1;
    end
    #1;
    chk("fill_extra_wr_en", int'(wr_en), 0);
    chk("fill_in_ready", int'(in_ready), 0);
    chk("fill_full", int'(fmap_full), 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("full_hold", int'(fmap_full), 1);

    // Full scan with a stray rd_start mid-scan; record every cycle.
    start_scan();
    chk("scan_full_drop", int'(fmap_full), 0);
    for (int j = 0; j < NREC; j++) begin
      if (j == 100) rd_start = 1'b1;
      if (j == 102) rd_start = 1'b0;
      @(posedge clk); #1;
      rec_addr[j] = int'(rd_addr);
      rec_val[j]  = int'(rd_data_valid);
      rec_pad[j]  = int'(rd_pad);
      rec_tl[j]   = int'(rd_tap_last);
      rec_wl[j]   = int'(rd_win_last);
      rec_done[j] = int'(done);
      rec_rdy[j]  = int'(in_ready);
    end

    // Tap n: address visible at record n, flags aligned with data at record n+1.
    for (int n = 0; n < NTAP; n++) begin
      chk("tap_addr", rec_addr[n], ref_addr(n));
      chk("tap_valid", rec_val[n+1], 1);
      chk("tap_pad", rec_pad[n+1], ref_pad(n));
      chk("tap_last", rec_tl[n+1], (n % 9 == 8) ? 1 : 0);
      chk("win_last", rec_wl[n+1], (n == NTAP - 1) ? 1 : 0);
    end

    // Hand-computed windows.
    addr_tab = '{0, 0, 0, 0, 0, 1, 0, 14, 15};
    pad_tab  = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
    for (int k = 0; k < 9; k++) begin
      chk("w00_addr", rec_addr[k], addr_tab[k]);
      chk("w00_pad", rec_pad[k+1], pad_tab[k]);
    end
    addr_tab = '{62, 63, 64, 76, 77, 78, 90, 91, 92};
    for (int k = 0; k < 9; k++) begin
      chk("w57_addr", rec_addr[77*9+k], addr_tab[k]);
      chk("w57_pad", rec_pad[77*9+k+1], 0);
    end
    addr_tab = '{180, 181, 0, 194, 195, 0, 0, 0, 0};
    pad_tab  = '{0, 0, 1, 0, 0, 1, 1, 1, 1};
    for (int k = 0; k < 9; k++) begin
      chk("w1313_addr", rec_addr[195*9+k], addr_tab[k]);
      chk("w1313_pad", rec_pad[195*9+k+1], pad_tab[k]);
    end

    // Stream-level counts and timing of done / in_ready.
    tl_cnt = 0; wl_cnt = 0; dn_cnt = 0; v_cnt = 0;
    for (int j = 0; j < NREC; j++) begin
      tl_cnt += rec_tl[j];
      wl_cnt += rec_wl[j];
      dn_cnt += rec_done[j];
      v_cnt  += rec_val[j];
    end
    chk("valid_count", v_cnt, NTAP);
    chk("valid_before", rec_val[0], 0);
    chk("valid_after", rec_val[NTAP+1], 0);
    chk("tap_last_count", tl_cnt, NPIX);
    chk("win_last_count", wl_cnt, 1);
    chk("done_count", dn_cnt, 1);
    chk("done_pos", rec_done[NTAP-1], 1);
    chk("ready_after_done", rec_rdy[NTAP], 1);
    chk("ready_during_done", rec_rdy[NTAP-1], 0);

    // Throttled refill, scan to tap 500, then asynchronous reset.
    fill_rand("tfill");
    start_scan();
    for (int j = 0; j <= 500; j++) begin
      @(posedge clk); #1;
    end
    chk("mid_scan_valid", int'(rd_data_valid), 1);
    chk("mid_scan_addr", int'(rd_addr), ref_addr(500));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Refill after reset must start at 0 and the scan must replay from window (0,0).
    fill_rand("rfill");
    start_scan();
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      rec_addr[j] = int'(rd_addr);
      rec_val[j]  = int'(rd_data_valid);
      rec_pad[j]  = int'(rd_pad);
      rec_tl[j]   = int'(rd_tap_last);
    end
    chk("replay_valid0", rec_val[0], 0);
    chk("replay_valid1", rec_val[1], 1);
    chk("replay_pad_t0", rec_pad[1], 1);
    chk("replay_addr_t4", rec_addr[4], 0);
    chk("replay_pad_t4", rec_pad[5], 0);
    chk("replay_addr_t5", rec_addr[5], 1);
    chk("replay_addr_t8", rec_addr[8], 15);
    chk("replay_tl_t8", rec_tl[9], 1);
    chk("replay_tl_t7", rec_tl[8], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmap_seq.md
# fmap_seq

Sequencer for one 16-bank feature-map buffer (16 channels × ROWS×COLS pixels, one channel per SRAM bank). It fills the buffer from the producing layer's pixel stream, then replays it to the consuming convolution engine as a same-padded 3×3 window tap stream. All 16 banks share one write address and one read address. The block sits between the pooling/activation output of layer N and the MAC array of layer N+1.

## Interface
- ADDR_WIDTH, 8, bank address width; must satisfy 2^ADDR_WIDTH ≥ ROWS*COLS
- ROWS, 14, feature-map height
- COLS, 14, feature-map width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  producer has a 16-channel pixel (data goes straight to the banks' write-data ports)
- in_ready  out  1  buffer accepts a pixel this cycle
- wr_en  out  1  write strobe, broadcast to all 16 banks
- wr_addr  out  ADDR_WIDTH  write address, broadcast
- fmap_full  out  1  all ROWS*COLS pixels stored; level signal
- rd_start  in  1  consumer requests a window scan; sampled only in FULL
- rd_addr  out  ADDR_WIDTH  read address, broadcast, registered
- rd_data_valid  out  1  bank rd_data is valid for a tap this cycle
- rd_pad  out  1  current tap is outside the map; consumer substitutes 0
- rd_tap_last  out  1  current tap is tap 8 of a window
- rd_win_last  out  1  current tap is tap 8 of the final window
- done  out  1  one-cycle pulse when the scan completes

## Operation
- States: IDLE, FILL, FULL, SCAN, FLUSH. Reset → IDLE.
- IDLE: in_ready=1. An accepted pixel moves the FSM to FILL.
- IDLE/FILL: wr_en = in_valid & in_ready (combinational). wr_addr = write counter, raster order r*COLS+c, starting at 0. Counter increments on each accepted pixel. When the pixel at address ROWS*COLS-1 is accepted, the next state is FULL.
- FULL: in_ready=0 and fmap_full=1. rd_start=1 moves the FSM to SCAN. rd_start in any other state is ignored.
- SCAN: one tap is issued per cycle, with no stalls.
  - Output positions (r,c) run in raster order.
  - Taps k=0..8 use dr=k/3-1 and dc=k%3-1, with row-major dr outer and dc inner.
  - Tap coordinate is (r+dr, c+dc). If it is in range, rd_addr=(r+dr)*COLS+(c+dc), computed from incremental row-base/column counters with no multiplier. If it is out of range, rd_addr=0 and the pad flag is set.
  - The last tap of the last window moves the FSM to FLUSH.
- FLUSH: one cycle. done=1 that cycle; the write counter and all scan counters clear; the FSM returns to IDLE. fmap_full falls on entry to SCAN.
- The write path is blocked outside IDLE/FILL, so buffer contents are never overwritten mid-scan.
- in_valid while in_ready=0 is held off by the producer; no data is lost.

## Timing
- Reset values: in_ready=1, wr_en=0 (in_valid low), wr_addr=0, fmap_full=0, rd_addr=0, rd_data_valid=0, rd_pad=0, rd_tap_last=0, rd_win_last=0, done=0.
- Asynchronous reset mid-FILL or mid-SCAN aborts immediately. Stored SRAM contents are don't-care; the next fill starts at address 0.
- Write: the pixel is written on the same edge it is accepted. A pixel accepted at the transition edge is the last write; in_ready is 0 from the next cycle.
- Read pipeline:
  - rd_addr is registered and valid the cycle after the tap is issued.
  - The banks have 1-cycle read latency.
  - rd_data_valid, rd_pad, rd_tap_last and rd_win_last are delayed so they align with bank rd_data, i.e. 2 cycles after the tap counter value.
- rd_start sampled at edge t: the first rd_data_valid appears at t+2. The scan issues exactly ROWS*COLS*9 taps (1764 at default) on consecutive cycles.
- done is asserted in the cycle after the last tap is issued. The final rd_data_valid (rd_win_last=1) arrives one cycle after done.
- Back-to-back operation: in_ready rises in the cycle after done, so a new fill can start while the final tap drains.

## Test plan
- Fill: stream 196 pixels with in_valid held high → wr_addr 0..195 on consecutive cycles, in_ready=0 and fmap_full=1 from the next cycle; a 197th in_valid gives no wr_en.
- Throttled fill: in_valid toggled randomly → exactly 196 writes, addresses strictly sequential, none skipped or repeated.
- Corner window (0,0):
  - taps 0,1,2,3,6 have rd_pad=1 and rd_addr=0;
  - taps 4,5,7,8 read addresses 0,1,14,15;
  - rd_tap_last on tap 8.
- Interior/edge windows: window (5,7) reads 62,63,64,76,77,78,90,91,92 with no pad; window (13,13) pads taps 2,5,6,7,8.
- Full scan: rd_start once → 1764 rd_data_valid cycles, contiguous; 196 rd_tap_last pulses; rd_win_last once, on the final tap; done one cycle earlier; rd_start during SCAN has no effect.
- Reset mid-SCAN at tap 500: all outputs return to reset values asynchronously; a refill followed by rd_start replays from window (0,0), tap 0.
